// File: rtl/rs_encode_line_out_ctrl.sv
// -----------------------------------------------------------------------------
// rs_encode_line_out_ctrl
//
// Output-side controller of the Reed-Solomon line encoder. Collects the
// encoder's codeword byte stream, packs it MSB-first into LINE_BYTES-wide
// lines and hands each line downstream over a val/rdy handshake. Once the
// final line of a codeword has been accepted it raises its done level and
// waits for the input-side controller's done level, so that both sides
// return to idle in the same cycle.
//
// Parameters
//   LINE_BYTES  bytes per output line (line width LINE_W = 8*LINE_BYTES)
//   RS_N        codeword length in bytes (data + parity), at most 255
//   RS_K        data bytes per codeword
//
// Ports
//   clk                        clock
//   rst                        synchronous, active-high reset
//   encoder_out_ctrl_byte_val  encoder byte valid
//   encoder_out_ctrl_byte      encoder byte
//   out_ctrl_encoder_byte_rdy  a byte is accepted this cycle if valid
//   dst_line_val               output line valid
//   dst_line_data              packed line, byte 0 at [LINE_W-1 -: 8]
//   dst_line_last              line is the final line of the codeword
//   dst_line_padbytes          zero pad bytes at the low end of the line
//   dst_line_rdy               downstream accepts the line
//   in_ctrl_out_ctrl_done      input side finished feeding the codeword
//   out_ctrl_in_ctrl_done      output side finished emitting the codeword
//
// Build option
//   RS_ENC_OUT_PARITY_ONLY_EN  when defined, the first RS_K bytes of every
//                              codeword are consumed but dropped, so only the
//                              RS_N-RS_K parity bytes are packed into lines.
// -----------------------------------------------------------------------------
module rs_encode_line_out_ctrl #(
  parameter int LINE_BYTES = 32,
  parameter int RS_N       = 255,
  parameter int RS_K       = 223,
  localparam int LINE_W    = 8 * LINE_BYTES,
  localparam int IDX_W     = $clog2(LINE_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              encoder_out_ctrl_byte_val,
  input  logic [7:0]        encoder_out_ctrl_byte,
  output logic              out_ctrl_encoder_byte_rdy,
  output logic              dst_line_val,
  output logic [LINE_W-1:0] dst_line_data,
  output logic              dst_line_last,
  output logic [IDX_W-1:0]  dst_line_padbytes,
  input  logic              dst_line_rdy,
  input  logic              in_ctrl_out_ctrl_done,
  output logic              out_ctrl_in_ctrl_done
);

  // Codeword byte counter width; RS_N is bounded by the 8-bit RS symbol size.
  localparam int CW_W = 8;

  typedef enum logic [1:0] {
    ST_COLLECT   = 2'd0,
    ST_SEND_LINE = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [LINE_W-1:0]  r_line;
  logic [IDX_W-1:0]   r_byte_idx;
  logic [CW_W-1:0]    r_cw_cnt;
  logic               r_last;
  logic [IDX_W-1:0]   r_padbytes;

  logic               w_byte_rdy;
  logic               w_line_val;
  logic               w_done_out;

  logic               w_byte_acc;
  logic               w_line_acc;
  logic               w_done_seen;
  logic               w_write;
  logic               w_cw_end;
  logic               w_line_full;
  logic               w_line_end;
  logic [LINE_W-1:0]  w_ins;

  // ---------------------------------------------------------------------------
  // Handshake events. They are decoded from the state register rather than
  // from the FSM's combinational outputs so the datapath never depends on the
  // next-state block (no combinational loop through the ready signals).
  // ---------------------------------------------------------------------------
  assign w_byte_acc  = (r_state == ST_COLLECT)   && encoder_out_ctrl_byte_val;
  assign w_line_acc  = (r_state == ST_SEND_LINE) && dst_line_rdy;
  assign w_done_seen = (r_state == ST_WAIT_DONE) && in_ctrl_out_ctrl_done;

  // Whether the byte currently offered is packed into the line.
`ifdef RS_ENC_OUT_PARITY_ONLY_EN
  // Data bytes occupy codeword positions 0..RS_K-1 and are consumed silently.
  assign w_write = (r_cw_cnt >= CW_W'(RS_K));
`else
  assign w_write = 1'b1;
`endif

  assign w_cw_end    = (r_cw_cnt == CW_W'(RS_N - 1));
  assign w_line_full = w_write && (r_byte_idx == IDX_W'(LINE_BYTES - 1));
  assign w_line_end  = w_cw_end || w_line_full;

  // Incoming byte moved to its MSB-first slot. The line register is cleared
  // after every send, so OR-ing the slot in leaves unwritten bytes at zero.
  assign w_ins = {encoder_out_ctrl_byte, {(LINE_W - 8){1'b0}}} >> {r_byte_idx, 3'b000};

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of the others, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_byte_rdy   = 1'b0;
    w_line_val   = 1'b0;
    w_done_out   = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        w_byte_rdy = 1'b1;
        if (encoder_out_ctrl_byte_val && w_line_end) begin
          w_state_next = ST_SEND_LINE;
        end
      end
      ST_SEND_LINE: begin
        w_line_val = 1'b1;
        if (dst_line_rdy) begin
          // r_last still holds this line's flag; it clears on the same edge.
          w_state_next = r_last ? ST_WAIT_DONE : ST_COLLECT;
        end
      end
      ST_WAIT_DONE: begin
        w_done_out = 1'b1;
        if (in_ctrl_out_ctrl_done) begin
          w_state_next = ST_COLLECT;
        end
      end
      default: begin
        // Unreachable encoding: poison everything so simulation exposes it.
        w_state_next = state_t'(2'bxx);
        w_byte_rdy   = 1'bx;
        w_line_val   = 1'bx;
        w_done_out   = 1'bx;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packing datapath: line register, write index, codeword counter and the
  // flags that travel with a line while it waits in SEND_LINE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line     <= '0;
      r_byte_idx <= '0;
      r_cw_cnt   <= '0;
      r_last     <= 1'b0;
      r_padbytes <= '0;
    end else begin
      if (w_byte_acc) begin
        r_cw_cnt <= r_cw_cnt + CW_W'(1);
        if (w_write) begin
          r_line <= r_line | w_ins;
        end
        if (w_line_end) begin
          // Freeze the line's flags; the index is cleared once the line goes.
          r_last     <= w_cw_end;
          r_padbytes <= IDX_W'(LINE_BYTES - 1) - r_byte_idx;
        end else if (w_write) begin
          r_byte_idx <= r_byte_idx + IDX_W'(1);
        end
      end

      if (w_line_acc) begin
        r_line     <= '0;
        r_byte_idx <= '0;
        r_last     <= 1'b0;
        r_padbytes <= '0;
      end

      if (w_done_seen) begin
        r_cw_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_ctrl_encoder_byte_rdy = w_byte_rdy;
  assign dst_line_val              = w_line_val;
  assign dst_line_data             = r_line;
  assign dst_line_last             = r_last;
  assign dst_line_padbytes         = r_padbytes;
  assign out_ctrl_in_ctrl_done     = w_done_out;

endmodule

// File: tb/tb_rs_encode_line_out_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rs_encode_line_out_ctrl
//
// Self-checking bench for rs_encode_line_out_ctrl. Each codeword is built in
// the bench, a reference model slices it into the expected lines (a plain
// byte queue chopped into LINE_BYTES chunks) and pushes them on a scoreboard.
// A negedge monitor pops and compares every accepted line and also checks the
// handshake timing: line valid one cycle after a line's final byte, done
// raised one cycle after the last line, done held while waiting, and the
// return to byte-ready one cycle after the done handshake.
// -----------------------------------------------------------------------------
module tb_rs_encode_line_out_ctrl;

  localparam int LB = 32;
  localparam int N  = 255;
  localparam int K  = 223;
  localparam int LW = 8 * LB;
  localparam int PW = $clog2(LB);

`ifdef RS_ENC_OUT_PARITY_ONLY_EN
  localparam int FIRST = K;
`else
  localparam int FIRST = 0;
`endif

  typedef logic [7:0] cw_t [N];

  typedef struct {
    logic [LW-1:0] data;
    logic          last;
    logic [PW-1:0] pad;
  } line_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          enc_val;
  logic [7:0]    enc_byte;
  logic          byte_rdy;
  logic          line_val;
  logic [LW-1:0] line_data;
  logic          line_last;
  logic [PW-1:0] line_pad;
  logic          line_rdy;
  logic          in_done;
  logic          out_done;

  always #5 clk = ~clk;

  rs_encode_line_out_ctrl #(
    .LINE_BYTES (LB),
    .RS_N       (N),
    .RS_K       (K)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .encoder_out_ctrl_byte_val (enc_val),
    .encoder_out_ctrl_byte     (enc_byte),
    .out_ctrl_encoder_byte_rdy (byte_rdy),
    .dst_line_val              (line_val),
    .dst_line_data             (line_data),
    .dst_line_last             (line_last),
    .dst_line_padbytes         (line_pad),
    .dst_line_rdy              (line_rdy),
    .in_ctrl_out_ctrl_done     (in_done),
    .out_ctrl_in_ctrl_done     (out_done)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  line_t sb[$];

  // Stimulus knobs shared with the background processes.
  bit    rdy_rand   = 1'b0;
  int    stall_left = 0;
  int    stall_line = 0;
  int    done_delay = 0;
  bit    noise_en   = 1'b0;

  // Monitor bookkeeping.
  int    mon_k       = 0;
  int    line_in_cw  = 0;
  bit    exp_val_next, prev_last_acc, prev_wait_hold, prev_done_seen, prev_stall;
  line_t held;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // Reference model: the packed byte stream is the whole codeword, or only its
  // parity tail in parity-only builds. It is cut into LINE_BYTES chunks; a
  // short final chunk only exists for a complete codeword and is zero padded.
  task automatic model_push(input cw_t cw, input int n);
    logic [7:0] pk[$];
    line_t      l;
    int         len;
    for (int i = FIRST; i < n; i++) pk.push_back(cw[i]);
    for (int base = 0; base < pk.size(); base += LB) begin
      len = (pk.size() - base < LB) ? pk.size() - base : LB;
      if (len < LB && n != N) break;
      l.data = '0;
      for (int j = 0; j < len; j++) l.data[LW-1-8*j -: 8] = pk[base+j];
      l.last = (n == N) && (base + len == pk.size());
      l.pad  = PW'(LB - len);
      sb.push_back(l);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic drive_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      enc_val = 1'b0;
      @(posedge clk); #1;
    end
    enc_val  = 1'b1;
    enc_byte = b;
    for (int t = 0; ; t++) begin
      if (t > 5000) begin
        n_tests++;
        n_fail++;
        $display("FAIL byte_accept_timeout: got no accept expected accept within 5000 cycles");
        finish_run();
      end
      if (byte_rdy) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    enc_val = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 one byte every third cycle, 2 random gaps.
  task automatic run_cw(input int nbytes, input bit rand_data, input int gap_mode);
    cw_t cw;
    int  gap;
    for (int i = 0; i < N; i++) cw[i] = rand_data ? 8'($urandom) : 8'(i);
    model_push(cw, nbytes);
    for (int i = 0; i < nbytes; i++) begin
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 3));
      drive_byte(cw[i], gap);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_rdy"}, LW'(byte_rdy), LW'(1));
    check({tag, "_line_val"}, LW'(line_val), LW'(0));
    check({tag, "_line_last"}, LW'(line_last), LW'(0));
    check({tag, "_line_pad"}, LW'(line_pad), LW'(0));
    check({tag, "_line_data"}, line_data, '0);
    check({tag, "_done"}, LW'(out_done), LW'(0));
  endtask

  // Downstream ready: optional forced stall on one line, else 1 or random.
  always begin
    @(posedge clk); #1;
    if (stall_left > 0 && line_val && line_in_cw == stall_line) begin
      line_rdy = 1'b0;
      stall_left--;
    end else if (rdy_rand) begin
      line_rdy = ($urandom_range(0, 3) != 0);
    end else begin
      line_rdy = 1'b1;
    end
  end

  // Input-side controller stand-in: answers done after done_delay cycles and,
  // when enabled, toggles its done level randomly while not being waited on.
  int done_cnt = 0;
  always begin
    @(posedge clk); #1;
    if (rst) begin
      in_done  = 1'b0;
      done_cnt = 0;
    end else if (out_done) begin
      if (done_cnt >= done_delay) begin
        in_done = 1'b1;
      end else begin
        in_done = 1'b0;
        done_cnt++;
      end
    end else begin
      done_cnt = 0;
      in_done  = noise_en && ($urandom_range(0, 7) == 0);
    end
  end

  // Monitor: inputs and outputs are stable at the negedge and describe what
  // the next rising edge will do.
  always @(negedge clk) begin
    line_t e;
    int    p;
    if (rst) begin
      mon_k          = 0;
      line_in_cw     = 0;
      exp_val_next   = 1'b0;
      prev_last_acc  = 1'b0;
      prev_wait_hold = 1'b0;
      prev_done_seen = 1'b0;
      prev_stall     = 1'b0;
    end else begin
      if (exp_val_next)  check("val_after_final_byte", LW'(line_val), LW'(1));
      if (prev_last_acc) check("done_rise", LW'(out_done), LW'(1));
      if (prev_wait_hold) check("done_held", LW'(out_done), LW'(1));
      if (prev_done_seen) begin
        check("done_exit_byte_rdy", LW'(byte_rdy), LW'(1));
        check("done_exit_done", LW'(out_done), LW'(0));
      end
      if (prev_stall) begin
        check("stall_val", LW'(line_val), LW'(1));
        check("stall_data", line_data, held.data);
        check("stall_last", LW'(line_last), LW'(held.last));
        check("stall_pad", LW'(line_pad), LW'(held.pad));
      end
      if (line_val) check("byte_rdy_low_in_send", LW'(byte_rdy), LW'(0));
      if (out_done) check("byte_rdy_low_in_wait", LW'(byte_rdy), LW'(0));

      exp_val_next   = 1'b0;
      prev_last_acc  = 1'b0;
      prev_wait_hold = 1'b0;
      prev_done_seen = 1'b0;
      prev_stall     = 1'b0;

      if (enc_val && byte_rdy) begin
        if (mon_k >= FIRST) begin
          p = mon_k - FIRST;
          if (mon_k == N - 1 || (p % LB) == LB - 1) exp_val_next = 1'b1;
        end
        mon_k = (mon_k == N - 1) ? 0 : mon_k + 1;
      end

      if (line_val && line_rdy) begin
        check("line_expected", LW'(sb.size() > 0), LW'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("line_data", line_data, e.data);
          check("line_last", LW'(line_last), LW'(e.last));
          check("line_pad", LW'(line_pad), LW'(e.pad));
          line_in_cw++;
          if (e.last) begin
            prev_last_acc = 1'b1;
            line_in_cw    = 0;
          end
        end
      end

      if (line_val && !line_rdy) begin
        prev_stall = 1'b1;
        held.data  = line_data;
        held.last  = line_last;
        held.pad   = line_pad;
      end
      if (out_done && !in_done) prev_wait_hold = 1'b1;
      if (out_done && in_done)  prev_done_seen = 1'b1;
    end
  end

  initial begin
    int t;
    enc_val  = 1'b0;
    enc_byte = 8'h00;
    line_rdy = 1'b1;
    in_done  = 1'b0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Full incrementing codeword, back-to-back, done answered after 10 cycles.
    done_delay = 10;
    run_cw(N, 1'b0, 0);

    // Downstream stall of 20 cycles on one line of the codeword.
    done_delay = 0;
    stall_line = (FIRST == 0) ? 3 : 0;
    stall_left = 20;
    run_cw(N, 1'b0, 0);

    // Sparse input: one byte every third cycle.
    run_cw(N, 1'b0, 1);

    // Reset after 100 bytes, then a clean codeword.
    run_cw(100, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("lines_drained_before_rst", LW'(sb.size()), LW'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("mid_cw_reset");
    rst = 1'b0;
    run_cw(N, 1'b0, 0);

    // Random data, random gaps, random downstream ready, stray done levels.
    noise_en = 1'b1;
    rdy_rand = 1'b1;
    for (int i = 0; i < 4; i++) begin
      done_delay = int'($urandom_range(0, 5));
      run_cw(N, 1'b1, 2);
    end

    // Let the last codeword drain and its done handshake complete.
    t = 0;
    while (t < 5000 && (sb.size() != 0 || !byte_rdy || line_val)) begin
      @(posedge clk); #1;
      t++;
    end
    check("final_drain", LW'(sb.size()), LW'(0));
    check("final_idle_byte_rdy", LW'(byte_rdy), LW'(1));
    finish_run();
  end

endmodule
